// File: rtl/spi_slave_responder.sv
// ============================================================================
// Module  : spi_slave_responder
// Brief   : SPI mode-0 slave emulating the radio register interface (byte
//           register file, status byte, write strobes). Optional burst
//           addressing is enabled by defining SPI_SLAVE_BURST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_responder #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              frame_active,
    output logic [7:0]        rx_byte,
    output logic              rx_valid,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int c_DEPTH = 2 ** ADDR_W;
`ifdef SPI_SLAVE_BURST_EN
    localparam bit c_BURST = 1'b1;
`else
    localparam bit c_BURST = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sck_d, r_ss_d;
    logic                   w_sck_s, w_ss_s, w_mosi_s;
    logic                   w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;

    logic [6:0]        r_rx_shift;
    logic [7:0]        r_tx_shift;
    logic [2:0]        r_bit_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_frame_cnt;
    logic              r_first_data;
    logic              r_miso;
    logic [7:0]        r_rx_byte;
    logic              r_rx_valid;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_regs [c_DEPTH];

    logic [7:0]        w_rx_byte;
    logic [7:0]        w_status;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_addr_one;
    logic              w_byte_done;
    logic              w_start;
    logic              w_cmd_done;
    logic              w_data_done;
    logic              w_act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= w_sck_s;
            r_ss_d      <= w_ss_s;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_ss_rise  = w_ss_s & ~r_ss_d;
    assign w_ss_fall  = ~w_ss_s & r_ss_d;

    assign w_rx_byte   = {r_rx_shift, w_mosi_s};
    assign w_status    = {1'b1, 3'b000, r_frame_cnt};
    assign w_cmd_addr  = w_rx_byte[ADDR_W-1:0];
    assign w_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    // Without burst support only the first data byte of a frame takes effect.
    assign w_act       = c_BURST | r_first_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cmd_done  = 1'b0;
        w_data_done = 1'b0;
        if (w_ss_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        w_state_nxt = S_CMD;
                        w_start     = 1'b1;
                    end
                end
                S_CMD: begin
                    if (w_byte_done) begin
                        w_cmd_done  = 1'b1;
                        w_state_nxt = w_rx_byte[7] ? S_WDATA : S_RDATA;
                    end
                end
                default: w_data_done = w_byte_done;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_bit_cnt    <= '0;
            r_addr       <= '0;
            r_frame_cnt  <= '0;
            r_first_data <= 1'b0;
            r_miso       <= 1'b0;
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            for (int i = 0; i < c_DEPTH; i++) r_regs[i] <= 8'h00;
        end else begin
            r_rx_valid  <= 1'b0;
            r_wr_strobe <= 1'b0;
            if (w_ss_rise) begin
                r_miso <= 1'b0;
                if (r_state == S_WDATA || r_state == S_RDATA)
                    r_frame_cnt <= r_frame_cnt + 4'd1;
            end else if (w_start) begin
                // Status MSB goes out immediately; the rest shifts on sck_fall.
                r_miso       <= w_status[7];
                r_tx_shift   <= {w_status[6:0], 1'b0};
                r_bit_cnt    <= '0;
                r_first_data <= 1'b1;
            end else if (r_state != S_IDLE) begin
                if (w_sck_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (w_sck_fall) begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
                if (w_cmd_done) begin
                    r_rx_byte  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                    if (w_rx_byte[7]) begin
                        r_addr     <= w_cmd_addr;
                        r_tx_shift <= w_status;
                    end else begin
                        r_tx_shift <= r_regs[w_cmd_addr];
                        r_addr     <= c_BURST ? w_cmd_addr + w_addr_one : w_cmd_addr;
                    end
                end
                if (w_data_done) begin
                    r_rx_byte    <= w_rx_byte;
                    r_rx_valid   <= 1'b1;
                    r_first_data <= 1'b0;
                    if (r_state == S_WDATA) begin
                        r_tx_shift <= w_status;
                        if (w_act) begin
                            r_regs[r_addr] <= w_rx_byte;
                            r_wr_strobe    <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_wr_data      <= w_rx_byte;
                            if (c_BURST) r_addr <= r_addr + w_addr_one;
                        end
                    end else begin
                        r_tx_shift <= c_BURST ? r_regs[r_addr] : 8'h00;
                        if (c_BURST) r_addr <= r_addr + w_addr_one;
                    end
                end
            end
        end
    end

    assign miso         = r_miso;
    assign frame_active = ~w_ss_s;
    assign rx_byte      = r_rx_byte;
    assign rx_valid     = r_rx_valid;
    assign wr_strobe    = r_wr_strobe;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
// ============================================================================
// Module  : tb_spi_slave_responder
// Brief   : Self-checking bench for spi_slave_responder using a small register
//           model and rx/write scoreboards (tracks SPI_SLAVE_BURST_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_responder;

`ifdef SPI_SLAVE_BURST_EN
    localparam bit c_BURST = 1'b1;
`else
    localparam bit c_BURST = 1'b0;
`endif
    localparam int c_AW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            sck;
    logic            ss;
    logic            mosi;
    logic            miso;
    logic            frame_active;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            wr_strobe;
    logic [c_AW-1:0] wr_addr;
    logic [7:0]      wr_data;

    spi_slave_responder #(.ADDR_W(c_AW), .SYNC_STAGES(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .sck          (sck),
        .ss           (ss),
        .mosi         (mosi),
        .miso         (miso),
        .frame_active (frame_active),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [7:0]      m_regs [64];
    logic [3:0]      m_fc;
    logic [7:0]      rx_q [$];
    logic [13:0]     wr_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumers for received bytes and register writes.
    always @(negedge clk) begin
        logic [7:0]  e_rx;
        logic [13:0] e_wr;
        if (rst && rx_valid) begin
            check("rx_pending", rx_q.size() > 0, 1);
            if (rx_q.size() > 0) begin
                e_rx = rx_q.pop_front();
                check("rx_byte", rx_byte, e_rx);
            end
        end
        if (rst && wr_strobe) begin
            check("wr_pending", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
                e_wr = wr_q.pop_front();
                check("wr_addr_data", {wr_addr, wr_data}, e_wr);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ss_low();
        ss = 1'b0;
        wait_clks(8);
    endtask

    task automatic ss_high();
        wait_clks(4);
        ss = 1'b1;
        wait_clks(10);
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            wait_clks(8);
            sck   = 1'b1;
            rx[i] = miso;
            wait_clks(8);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n, input int tail_bits);
        logic [7:0]      tx [4];
        logic [7:0]      got;
        logic [7:0]      expb;
        logic [7:0]      status;
        logic [c_AW-1:0] a;
        tx = '{b0, b1, b2, 8'h5A};
        status = {4'b1000, m_fc};
        a = tx[0][c_AW-1:0];
        ss_low();
        check("frame_active", frame_active, 1);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                expb = status;
            end else if (tx[0][7]) begin
                expb = status;
                if (c_BURST || i == 1) begin
                    m_regs[a] = tx[i];
                    wr_q.push_back({a, tx[i]});
                    if (c_BURST) a = a + 1'b1;
                end
            end else begin
                expb = (c_BURST || i == 1) ? m_regs[a] : 8'h00;
                if (c_BURST) a = a + 1'b1;
            end
            rx_q.push_back(tx[i]);
            xfer_byte(tx[i], 8, got);
            check($sformatf("miso_byte%0d_cmd%02h", i, tx[0]), got, expb);
        end
        if (tail_bits > 0) xfer_byte(tx[n], tail_bits, got);
        ss_high();
        if (n > 0) m_fc = m_fc + 4'd1;
    endtask

    initial begin
        logic [7:0] got;
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_fc = 4'd0;
        rst  = 1'b0;
        sck  = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        wait_clks(5);
        check("rst_miso", miso, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b1;
        wait_clks(5);

        run_frame(8'h00, 8'h00, 8'h00, 2, 0);   // status 0x80 then reg0
        run_frame(8'h85, 8'h3C, 8'hA7, 3, 0);   // write at 5 (and 6 in burst)
        run_frame(8'h05, 8'h00, 8'h00, 3, 0);
        run_frame(8'hBF, 8'h11, 8'h22, 3, 0);   // address 63 wraps to 0
        run_frame(8'h3F, 8'h00, 8'h00, 3, 0);
        run_frame(8'h82, 8'h99, 8'h00, 1, 4);   // data byte cut short
        run_frame(8'h02, 8'h00, 8'h00, 2, 0);
        run_frame(8'h83, 8'h55, 8'h66, 3, 0);
        run_frame(8'h03, 8'h00, 8'h00, 2, 0);
        run_frame(8'h04, 8'h00, 8'h00, 2, 0);

        // Reset in the middle of a read frame.
        ss_low();
        rx_q.push_back(8'h05);
        xfer_byte(8'h05, 8, got);
        check("pre_rst_status", got, {4'b1000, m_fc});
        xfer_byte(8'h00, 3, got);
        rst = 1'b0;
        wait_clks(1);
        check("midrst_miso", miso, 0);
        check("midrst_frame_active", frame_active, 0);
        check("midrst_rx_byte", rx_byte, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_wr_strobe", wr_strobe, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        ss  = 1'b1;
        sck = 1'b0;
        wait_clks(4);
        rst = 1'b1;
        wait_clks(6);
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_fc = 4'd0;
        run_frame(8'h05, 8'h00, 8'h00, 2, 0);

        wait_clks(10);
        check("rx_q_drained", rx_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI mode-0 slave that emulates the radio transceiver's register interface, so the existing SPI master path can be exercised in simulation and on the bench without the radio fitted.
- Oversamples SCLK/SS/MOSI in the system clock domain and decodes a command byte followed by data bytes.
- Keeps an internal byte register file, drives MISO, and exposes write strobes for observation by the debug LEDs and the bench.

Parameters:
- ADDR_W, 6, register address width; the register file has 2**ADDR_W bytes.
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on sck, ss and mosi (minimum 2).

Ports:
- clk  input  1  system clock (26 MHz domain); sck must not exceed clk/8.
- rst  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from master; idles low (mode 0).
- ss  input  1  slave select, active-low.
- mosi  input  1  master-out data, MSB first.
- miso  output  1  slave-out data, MSB first.
- frame_active  output  1  high while synchronised ss is low.
- rx_byte  output  8  last complete byte received.
- rx_valid  output  1  one-clk pulse when rx_byte updates.
- wr_strobe  output  1  one-clk pulse when a register is written.
- wr_addr  output  ADDR_W  address of the last write.
- wr_data  output  8  data of the last write.

Behaviour:
- Reset (rst=0): all outputs 0; FSM in IDLE; register file cleared to 0x00; frame_cnt=0; all synchroniser stages cleared (ss stages to 1).
- Synchronisation and edges: sck_rise and sck_fall are single-clk pulses derived from the synchronised sck. Sample and shift logic acts SYNC_STAGES+1 clks after the pin edge.
- Bit timing:
  - On sck_rise: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt increments mod 8.
  - On sck_fall: miso <= next tx bit.
- Status byte: {1'b1, 3'b000, frame_cnt[3:0]}.
- Command byte: bit7 = 1 selects WRITE, 0 selects READ. Bits[ADDR_W-1:0] give the start address. Bits above ADDR_W in [6:0] are ignored.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE: miso=0. When ss_s falls, go to CMD, load tx_shift with the status byte, drive miso = status[7] on the same clk, and set bit_cnt=0.
  - CMD: at the 8th sck_rise, latch the command, pulse rx_valid, and set addr. Go to WDATA or RDATA.
    - For READ, load tx_shift with reg[addr] and post-increment addr.
    - For WRITE, reload the status byte.
  - WDATA: at each 8th sck_rise, write reg[addr] <= byte, pulse wr_strobe and rx_valid, and update wr_addr/wr_data. Post-increment addr mod 2**ADDR_W. Reload tx_shift with status.
  - RDATA: at each 8th sck_rise, pulse rx_valid (rx_byte = mosi byte, ignored otherwise). Load tx_shift <= reg[addr] and post-increment addr.
- MISO timing: the byte loaded at an 8th sck_rise has its MSB driven on the following sck_fall. The remaining 7 bits follow on subsequent sck_falls.
- ss_s rising in any state:
  - Return to IDLE; miso=0.
  - Discard a partial byte: no write, no rx_valid.
  - If at least the command byte completed, frame_cnt increments mod 16.
- Address wrap: addr 2**ADDR_W-1 increments to 0.
- Simultaneity: a write to reg[addr] and a read load in the same clk cannot occur, because a frame is write-only or read-only.
- rst asserted mid-frame: immediate return to IDLE and full register clear; the frame is dropped.
- A sck edge seen while ss_s is high is ignored.

Optional Feature:
- SPI_SLAVE_BURST_EN
  - Defined: addr auto-increments after every data byte, so burst reads and writes are supported.
  - Undefined: only the first data byte after the command is acted on. Later bytes in the frame produce rx_valid, but no write occurs and they read back 0x00. addr does not increment.

Test Plan:
- Reset, then frame with command 0x00 plus one dummy byte -> miso byte0 = 0x80; byte1 = 0x00; after ss high, next status = 0x81.
- Write frame 0x85, 0x3C, 0xA7 -> wr_strobe twice with (addr 5, 0x3C) then (addr 6, 0xA7). Subsequent read frame 0x05 plus 2 dummies returns 0x3C, 0xA7 (burst build).
- Burst write starting at 0xBF (addr 63) with 0x11, 0x22 -> writes reg63=0x11, then reg0=0x22 (wrap).
- Write frame 0x82, then ss deasserted after 4 bits of data -> no wr_strobe; reg2 stays 0x00; frame_cnt still increments.
- rst pulsed low mid read frame -> miso=0 within 1 clk; all outputs 0; a subsequent read of reg5 returns 0x00.
- Build without SPI_SLAVE_BURST_EN: write frame 0x83, 0x55, 0x66 -> one wr_strobe (addr 3, 0x55); reg4 unchanged.
